// File: rtl/par_to_ser_feeder_pkg.sv
// Shared types and constants for the parallel-to-serial feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package par_to_ser_feeder_pkg;

  // Pattern width of the downstream sequence detector; the feeder word width defaults to it.
  localparam int DET_W = 5;

  // Feeder FSM: IDLE drives the idle bit, SHIFT presents the head of the shift register.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bit-counter width for a W-bit word. It must hold W-1. Widths below 2 are clamped to 1 bit.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/par_to_ser_feeder_if.sv
// Word-in / bit-out handshake bundle between a word producer, the feeder and the detector.
// Latency: n/a (wiring only).
// Backpressure: din_ready is driven by the feeder; there is no backpressure on the serial side.
interface par_to_ser_feeder_if
  import par_to_ser_feeder_pkg::*;
#(
  parameter int W = DET_W
) ();

  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         shift_en;
  logic         sout;
  logic         sout_valid;
  logic         busy;
  logic         word_done;

  // Producer side: drives words and the bit-rate enable, and observes the serial stream.
  modport master (
    output din, din_valid, shift_en,
    input  din_ready, sout, sout_valid, busy, word_done
  );

  // Feeder side.
  modport slave (
    input  din, din_valid, shift_en,
    output din_ready, sout, sout_valid, busy, word_done
  );

endinterface

// File: rtl/par_to_ser_feeder_ser_bit_cnt.sv
// Down-counter that tracks the bits left in the word being shifted out.
// Latency: a load or decrement becomes visible one clock after the edge.
// Backpressure: none; the counter holds its value unless i_load or i_dec is set.
module ser_bit_cnt #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          g_rst,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_dec,
  output logic          o_zero
);

  logic [CW-1:0] r_cnt;

  // Load has priority over decrement, and the count never wraps below zero.
  always_ff @(posedge clk or posedge g_rst) begin
    if (g_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/par_to_ser_feeder.sv
// Serializes W-bit words onto one bit line. A one-word holding register keeps back-to-back words gap-free.
// Latency: the first bit is valid 1 cycle after the accept edge. A word occupies W shift_en cycles.
// Backpressure: din_ready = ~hold_full. It depends only on registers, never on din_valid.
module par_to_ser_feeder
  import par_to_ser_feeder_pkg::*;
#(
  parameter int W         = DET_W,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic                   clk,
  input  logic                   g_rst,
  par_to_ser_feeder_if.slave     bus
);

  localparam int            CW       = cnt_width(W);
  localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);

  // Registered state.
  state_t         r_state;
  logic [W-1:0]   r_shift;
  logic [W-1:0]   r_hold;
  logic           r_hold_full;
  logic           r_sout;
  logic           r_sout_valid;
  logic           r_busy;
  logic           r_word_done;

  // Next-state and control wires.
  state_t         w_state_nxt;
  logic [W-1:0]   w_shift_nxt;
  logic [W-1:0]   w_hold_nxt;
  logic           w_hold_full_nxt;
  logic           w_word_done_nxt;
  logic           w_accept;
  logic           w_cnt_load;
  logic           w_cnt_dec;
  logic           w_cnt_zero;

  // Bit currently presented on the line.
  function automatic logic head_bit(input logic [W-1:0] v);
    return MSB_FIRST ? v[W-1] : v[0];
  endfunction

  // Advance the shift register one position toward the head.
  function automatic logic [W-1:0] shift_one(input logic [W-1:0] v);
    return MSB_FIRST ? {v[W-2:0], 1'b0} : {1'b0, v[W-1:1]};
  endfunction

  // Ready is derived from the holding register alone, so din_valid cannot form a loop.
  assign w_accept = bus.din_valid & ~r_hold_full;

  ser_bit_cnt #(
    .CW (CW)
  ) u_bit_cnt (
    .clk        (clk),
    .g_rst      (g_rst),
    .i_load     (w_cnt_load),
    .i_load_val (LAST_IDX),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  // Next-state logic: load, shift, drain the holding register, or bypass it on the last bit.
  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_hold_nxt      = r_hold;
    w_hold_full_nxt = r_hold_full;
    w_word_done_nxt = 1'b0;
    w_cnt_load      = 1'b0;
    w_cnt_dec       = 1'b0;
    case (r_state)
      IDLE: begin
        // The load ignores shift_en. The first bit goes out in the next cycle.
        if (w_accept) begin
          w_shift_nxt = bus.din;
          w_cnt_load  = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.shift_en && w_cnt_zero) begin
          // The last bit of the word is consumed on this edge.
          w_word_done_nxt = 1'b1;
          if (r_hold_full) begin
            // Drain the holding register so no idle bit is inserted.
            w_shift_nxt     = r_hold;
            w_cnt_load      = 1'b1;
            // A word arriving on the drain edge refills the holding register.
            w_hold_full_nxt = w_accept;
            if (w_accept) begin
              w_hold_nxt = bus.din;
            end
          end else if (w_accept) begin
            // Bypass: the word arrives on the last-bit edge and goes straight into the shifter.
            w_shift_nxt = bus.din;
            w_cnt_load  = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          if (bus.shift_en) begin
            w_shift_nxt = shift_one(r_shift);
            w_cnt_dec   = 1'b1;
          end
          if (w_accept) begin
            w_hold_nxt      = bus.din;
            w_hold_full_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // FSM state, data registers and registered outputs. Reset discards any partial or held word.
  always_ff @(posedge clk or posedge g_rst) begin
    if (g_rst) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_hold       <= '0;
      r_hold_full  <= 1'b0;
      r_sout       <= IDLE_BIT;
      r_sout_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_word_done  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_hold       <= w_hold_nxt;
      r_hold_full  <= w_hold_full_nxt;
      r_sout       <= (w_state_nxt == SHIFT) ? head_bit(w_shift_nxt) : IDLE_BIT;
      r_sout_valid <= (w_state_nxt == SHIFT);
      r_busy       <= (w_state_nxt == SHIFT) | w_hold_full_nxt;
      r_word_done  <= w_word_done_nxt;
    end
  end

  assign bus.din_ready  = ~r_hold_full;
  assign bus.sout       = r_sout;
  assign bus.sout_valid = r_sout_valid;
  assign bus.busy       = r_busy;
  assign bus.word_done  = r_word_done;

endmodule

// File: tb/tb_par_to_ser_feeder.sv
// Scoreboard bench for par_to_ser_feeder (W=5, MSB first, idle bit 0).
// Stimulus pushes the hand-written serial pattern of each accepted word into a queue.
// A negedge monitor pops one bit per enabled cycle and checks sout, sout_valid and word_done.
module tb_par_to_ser_feeder;

  localparam int W = 5;

  typedef struct {
    logic b;
    logic last;
  } exp_t;

  logic       clk   = 1'b0;
  logic       g_rst = 1'b0;
  int         n_chk  = 0;
  int         n_fail = 0;
  exp_t       q[$];
  logic       wd_pend = 1'b0;
  logic [W-1:0] cur_exp = '0;
  logic [14:0]  stall_pat;

  par_to_ser_feeder_if #(.W(W)) bus ();

  par_to_ser_feeder #(
    .W         (W),
    .MSB_FIRST (1'b1),
    .IDLE_BIT  (1'b0)
  ) dut (
    .clk   (clk),
    .g_rst (g_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue the expected serial bits in transmission order, from the leftmost written bit.
  task automatic push_exp(input logic [W-1:0] pat);
    for (int i = W - 1; i >= 0; i--) begin
      q.push_back('{b: pat[i], last: (i == 0)});
    end
  endtask

  // One clock edge. An accept seen before the edge queues the current expected pattern.
  task automatic tick();
    logic acc;
    acc = bus.din_valid & bus.din_ready;
    @(posedge clk);
    if (acc === 1'b1) push_exp(cur_exp);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sout"},       bus.sout,       1'b0);
    chk({tag, "_sout_valid"}, bus.sout_valid, 1'b0);
    chk({tag, "_din_ready"},  bus.din_ready,  1'b1);
    chk({tag, "_busy"},       bus.busy,       1'b0);
    chk({tag, "_word_done"},  bus.word_done,  1'b0);
  endtask

  // Monitor: compares the DUT stream against the queue away from the active edge.
  always @(negedge clk) begin
    if (g_rst) begin
      q.delete();
      wd_pend = 1'b0;
    end else begin
      chk("mon_word_done", bus.word_done, wd_pend);
      wd_pend = 1'b0;
      chk("mon_sout_valid", bus.sout_valid, (q.size() != 0));
      if (q.size() != 0) begin
        chk("mon_sout_bit", bus.sout, q[0].b);
        if (bus.shift_en) begin
          if (q[0].last) wd_pend = 1'b1;
          void'(q.pop_front());
        end
      end else begin
        chk("mon_idle_bit", bus.sout, 1'b0);
      end
    end
  end

  initial begin
    bus.din       = '0;
    bus.din_valid = 1'b0;
    bus.shift_en  = 1'b1;

    // Reset asserted between edges: the outputs must settle without a clock.
    #2 g_rst = 1'b1;
    #1 chk_reset_vals("rst0");
    @(posedge clk);
    #1 g_rst = 1'b0;
    tick(); tick();

    // Single word 01101: bits 0,1,1,0,1 then word_done in cycle 6.
    bus.din = 5'b01101; cur_exp = 5'b01101; bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    repeat (5) tick();
    chk("single_word_done", bus.word_done, 1'b1);
    chk("single_busy_after", bus.busy, 1'b0);
    chk("single_ready_after", bus.din_ready, 1'b1);
    tick(); tick();

    // Back-to-back 01101 then 10110: gap-free stream 0110110110.
    bus.din = 5'b01101; cur_exp = 5'b01101; bus.din_valid = 1'b1;
    tick();
    bus.din = 5'b10110; cur_exp = 5'b10110;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("b2b_ready_low", bus.din_ready, 1'b0);
      chk("b2b_busy", bus.busy, 1'b1);
      // A word offered while not ready must not be taken.
      if (i == 3) bus.din_valid = 1'b0;
      else begin bus.din = 5'b11111; bus.din_valid = 1'b1; end
      tick();
    end
    chk("b2b_ready_after_drain", bus.din_ready, 1'b1);
    chk("b2b_first_word_done", bus.word_done, 1'b1);
    repeat (6) tick();

    // Stall: shift_en 1,0,0,1,... The word needs 5 enabled edges.
    bus.din = 5'b10011; cur_exp = 5'b10011; bus.din_valid = 1'b1; bus.shift_en = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    stall_pat = 15'b100100100100100;
    for (int i = 0; i < 15; i++) begin
      bus.shift_en = stall_pat[14 - i];
      tick();
      if (i == 7) chk("stall_busy", bus.busy, 1'b1);
    end
    bus.shift_en = 1'b1;
    tick(); tick();

    // Bypass: the next word is offered exactly on the last-bit edge.
    bus.din = 5'b11010; cur_exp = 5'b11010; bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    repeat (4) tick();
    bus.din = 5'b00111; cur_exp = 5'b00111; bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    chk("bypass_hold_empty", bus.din_ready, 1'b1);
    chk("bypass_busy", bus.busy, 1'b1);
    chk("bypass_no_gap", bus.sout_valid, 1'b1);
    repeat (6) tick();

    // Reset mid-word with the holding register full, then a clean 00001.
    bus.din = 5'b01101; cur_exp = 5'b01101; bus.din_valid = 1'b1;
    tick();
    bus.din = 5'b10110; cur_exp = 5'b10110;
    tick();
    bus.din_valid = 1'b0;
    tick();
    chk("midrst_pre_ready", bus.din_ready, 1'b0);
    #1 g_rst = 1'b1;
    #1 chk_reset_vals("midrst");
    @(posedge clk);
    #1 g_rst = 1'b0;
    tick();
    chk("midrst_after_busy", bus.busy, 1'b0);
    bus.din = 5'b00001; cur_exp = 5'b00001; bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    repeat (7) tick();

    // Bounded drain: every expected bit must have been seen.
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    chk("drain_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
